// File: rtl/boost_duty_ctrl_if.sv
// boost_duty_ctrl_if
//   Groups the run/target/fault controls and the PWM-facing outputs of
//   boost_duty_ctrl. DW must match the DW of the controller it is bound to.
//   master : drives en, d_target, fault, fault_clr; observes the outputs
//   slave  : the controller side
interface boost_duty_ctrl_if #(
  parameter int DW = 10
);
  logic          en;
  logic [DW-1:0] d_target;
  logic          fault;
  logic          fault_clr;
  logic [DW-1:0] d_out;
  logic          pwm_en;
  logic          period_start;
  logic          at_target;
  logic          fault_latched;
  logic [1:0]    state;

  modport master (
    output en, d_target, fault, fault_clr,
    input  d_out, pwm_en, period_start, at_target, fault_latched, state
  );

  modport slave (
    input  en, d_target, fault, fault_clr,
    output d_out, pwm_en, period_start, at_target, fault_latched, state
  );
endinterface

// File: rtl/boost_duty_ctrl.sv
// boost_duty_ctrl
//   Soft-start and protection sequencer for the boost converter PWM stage.
//   Ramps duty from 0 to min(d_target, MAX_DUTY), follows later target
//   changes, and forces duty to 0 on disable or fault. Duty only moves at
//   period boundaries so the PWM never sees a mid-period step.
// Ports
//   clk                 in   system clock
//   rst                 in   asynchronous reset, active-high
//   bus.en              in   converter run request
//   bus.d_target[DW]    in   requested duty, counts
//   bus.fault           in   overcurrent/overvoltage level, synchronous to clk
//   bus.fault_clr       in   fault acknowledge
//   bus.d_out[DW]       out  duty to the PWM d input
//   bus.pwm_en          out  PWM enable (RAMP or RUN)
//   bus.period_start    out  strobe on the last cycle of each PWM period
//   bus.at_target       out  high in RUN
//   bus.fault_latched   out  high in FAULT
//   bus.state[2]        out  current state encoding
//
// state | meaning
// IDLE  | converter off, duty 0, waiting for en
// RAMP  | stepping duty up by STEP every STEP_PERIODS periods toward target
// RUN   | duty at target; follows decreases directly, increases via RAMP
// FAULT | duty 0, PWM off until fault_clr with fault and en both low
module boost_duty_ctrl #(
  parameter int PERIOD       = 100,
  parameter int DW           = 10,
  parameter int MAX_DUTY     = 90,
  parameter int STEP         = 1,
  parameter int STEP_PERIODS = 4
) (
  input  logic              clk,
  input  logic              rst,
  boost_duty_ctrl_if.slave  bus
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] cnt_q;
  logic          period_start_q;
  logic [SW-1:0] step_q;
  logic [DW-1:0] d_q;
  logic          pwm_en_q;
  logic          at_target_q;
  logic          fault_latched_q;

  logic [DW-1:0] tgt;
  logic [DW:0]   ramp_sum;
  logic [DW-1:0] ramp_d;

  assign tgt      = (bus.d_target > DW'(MAX_DUTY)) ? DW'(MAX_DUTY) : bus.d_target;
  // One extra bit so the add cannot wrap before the saturation compare.
  assign ramp_sum = {1'b0, d_q} + (DW+1)'(STEP);
  assign ramp_d   = (ramp_sum >= {1'b0, tgt}) ? tgt : ramp_sum[DW-1:0];

  // period_start is registered from the pre-wrap count so that it is high
  // exactly while cnt_q == PERIOD-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      if (cnt_q == PW'(PERIOD-1)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + PW'(1);
      end
      period_start_q <= (cnt_q == PW'(PERIOD-2));
    end
  end

  // Outputs are written alongside each state change so they stay registered
  // and always consistent with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      d_q             <= '0;
      step_q          <= '0;
      pwm_en_q        <= 1'b0;
      at_target_q     <= 1'b0;
      fault_latched_q <= 1'b0;
    end else if (bus.fault) begin
      state_q         <= FAULT;
      d_q             <= '0;
      pwm_en_q        <= 1'b0;
      at_target_q     <= 1'b0;
      fault_latched_q <= 1'b1;
    end else if (!bus.en && state_q != FAULT) begin
      // Disable is immediate; it does not wait for a period boundary.
      state_q     <= IDLE;
      d_q         <= '0;
      pwm_en_q    <= 1'b0;
      at_target_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q  <= RAMP;
          d_q      <= '0;
          step_q   <= '0;
          pwm_en_q <= 1'b1;
        end
        RAMP: begin
          if (period_start_q) begin
            if (d_q >= tgt) begin
              d_q         <= tgt;
              state_q     <= RUN;
              at_target_q <= 1'b1;
            end else if (step_q == SW'(STEP_PERIODS-1)) begin
              d_q    <= ramp_d;
              step_q <= '0;
            end else begin
              step_q <= step_q + SW'(1);
            end
          end
        end
        RUN: begin
          if (period_start_q) begin
            if (tgt < d_q) begin
              d_q <= tgt;
            end else if (tgt > d_q) begin
              state_q     <= RAMP;
              step_q      <= '0;
              at_target_q <= 1'b0;
            end
          end
        end
        FAULT: begin
          // fault is already known low here; en must be low too.
          if (bus.fault_clr && !bus.en) begin
            state_q         <= IDLE;
            fault_latched_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.d_out         = d_q;
  assign bus.pwm_en        = pwm_en_q;
  assign bus.period_start  = period_start_q;
  assign bus.at_target     = at_target_q;
  assign bus.fault_latched = fault_latched_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_boost_duty_ctrl.sv
module tb_boost_duty_ctrl;
  localparam int PERIOD       = 100;
  localparam int DW           = 10;
  localparam int MAX_DUTY     = 90;
  localparam int STEP         = 1;
  localparam int STEP_PERIODS = 4;

  logic clk;
  logic rst;

  boost_duty_ctrl_if #(.DW(DW)) bus_if ();

  boost_duty_ctrl #(
    .PERIOD(PERIOD), .DW(DW), .MAX_DUTY(MAX_DUTY),
    .STEP(STEP), .STEP_PERIODS(STEP_PERIODS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;
  int max_d = 0;

  // Reference model: abstract state number, duty as an integer, edges since
  // reset (period position is derived from it), and period boundaries seen
  // since the current ramp began.
  int m_k, m_st, m_d, m_pb;

  logic [15:0] dut_vec;
  assign dut_vec = {bus_if.state, bus_if.fault_latched, bus_if.at_target,
                    bus_if.period_start, bus_if.pwm_en, bus_if.d_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k  = 0;
    m_st = 0;
    m_d  = 0;
    m_pb = 0;
  endtask

  task automatic model_step();
    bit ps;
    int tgt;
    ps  = (m_k % PERIOD) == PERIOD-1;
    tgt = (int'(bus_if.d_target) > MAX_DUTY) ? MAX_DUTY : int'(bus_if.d_target);
    if (bus_if.fault) begin
      m_st = 3;
      m_d  = 0;
    end else if (!bus_if.en && m_st != 3) begin
      m_st = 0;
      m_d  = 0;
    end else begin
      case (m_st)
        0: begin
          m_st = 1;
          m_pb = 0;
          m_d  = 0;
        end
        1: if (ps) begin
          if (m_d >= tgt) begin
            m_d  = tgt;
            m_st = 2;
          end else begin
            m_pb++;
            if (m_pb % STEP_PERIODS == 0) m_d = (m_d + STEP > tgt) ? tgt : m_d + STEP;
          end
        end
        2: if (ps) begin
          if (tgt < m_d) m_d = tgt;
          else if (tgt > m_d) begin
            m_st = 1;
            m_pb = 0;
          end
        end
        default: if (bus_if.fault_clr && !bus_if.en) m_st = 0;
      endcase
    end
    m_k++;
  endtask

  function automatic logic [15:0] exp_vec();
    logic [1:0] st;
    logic fl, at, ps, pe;
    st = 2'(m_st);
    fl = (m_st == 3);
    at = (m_st == 2);
    ps = ((m_k % PERIOD) == PERIOD-1);
    pe = (m_st == 1 || m_st == 2);
    return {st, fl, at, ps, pe, DW'(m_d)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    n_cyc++;
    if (int'(bus_if.d_out) > max_d) max_d = int'(bus_if.d_out);
    chk("cyc", {16'd0, dut_vec}, {16'd0, exp_vec()});
  endtask

  int t1, len, r;

  initial begin
    rst              = 1'b1;
    bus_if.en        = 1'b0;
    bus_if.d_target  = '0;
    bus_if.fault     = 1'b0;
    bus_if.fault_clr = 1'b0;
    model_reset();
    #1;
    chk("rst_d_out", bus_if.d_out, 0);
    chk("rst_state", bus_if.state, 0);
    chk("rst_pwm_en", bus_if.pwm_en, 0);
    chk("rst_pstart", bus_if.period_start, 0);
    chk("rst_flags", {bus_if.at_target, bus_if.fault_latched}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Async reset in the middle of a ramp, between clock edges.
    bus_if.en       = 1'b1;
    bus_if.d_target = DW'(20);
    for (int i = 0; i < 4000 && bus_if.d_out != 7; i++) cycle();
    chk("s1_reach7", bus_if.d_out, 7);
    chk("s1_ramp", bus_if.state, 1);
    #2 rst = 1'b1;
    #1;
    chk("s1_async_d", bus_if.d_out, 0);
    chk("s1_async_st", bus_if.state, 0);
    chk("s1_async_pe", bus_if.pwm_en, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Default ramp to 20: one count every STEP_PERIODS periods.
    for (int i = 0; i < 1000 && bus_if.d_out != 1; i++) cycle();
    chk("s2_d1", bus_if.d_out, 1);
    t1 = n_cyc;
    for (int i = 0; i < 1000 && bus_if.d_out != 2; i++) cycle();
    chk("s2_step_gap", n_cyc - t1, PERIOD * STEP_PERIODS);
    for (int i = 0; i < 9000 && bus_if.state != 2; i++) cycle();
    chk("s2_run", bus_if.state, 2);
    chk("s2_d20", bus_if.d_out, 20);
    chk("s2_at_tgt", bus_if.at_target, 1);

    // Oversized target saturates at MAX_DUTY.
    max_d = 0;
    bus_if.d_target = DW'(1023);
    for (int i = 0; i < 30000 && !(bus_if.state == 2 && bus_if.d_out == 90); i++) cycle();
    chk("s3_d90", bus_if.d_out, 90);
    chk("s3_run", bus_if.state, 2);
    repeat (300) cycle();
    chk("s3_hold90", bus_if.d_out, 90);
    chk("s3_at_tgt", bus_if.at_target, 1);
    chk("s3_max_le90", max_d > 90, 0);

    // Decrease applies at a period boundary; increase goes through RAMP.
    bus_if.d_target = DW'(20);
    for (int i = 0; i < 120 && bus_if.d_out != 20; i++) cycle();
    chk("s4_d20", bus_if.d_out, 20);
    bus_if.d_target = DW'(5);
    for (int i = 0; i < 120 && bus_if.d_out != 5; i++) cycle();
    chk("s4_d5", bus_if.d_out, 5);
    chk("s4_run", bus_if.state, 2);
    bus_if.d_target = DW'(8);
    for (int i = 0; i < 120 && bus_if.state != 1; i++) cycle();
    chk("s4_ramp", bus_if.state, 1);
    for (int i = 0; i < 500 && bus_if.d_out != 6; i++) cycle();
    chk("s4_d6", bus_if.d_out, 6);
    for (int i = 0; i < 500 && bus_if.d_out != 7; i++) cycle();
    chk("s4_d7", bus_if.d_out, 7);
    for (int i = 0; i < 1000 && bus_if.state != 2; i++) cycle();
    chk("s4_run8", {bus_if.state, bus_if.d_out}, {2'd2, DW'(8)});

    // Fault latches; clear needs en low as well.
    bus_if.fault = 1'b1;
    cycle();
    chk("s5_d0", bus_if.d_out, 0);
    chk("s5_pe0", bus_if.pwm_en, 0);
    chk("s5_st3", bus_if.state, 3);
    chk("s5_latched", bus_if.fault_latched, 1);
    bus_if.fault     = 1'b0;
    bus_if.fault_clr = 1'b1;
    repeat (3) cycle();
    chk("s5_clr_en1", bus_if.state, 3);
    bus_if.en = 1'b0;
    cycle();
    chk("s5_idle", bus_if.state, 0);
    bus_if.fault_clr = 1'b0;

    // Disable mid-period in RAMP; simultaneous fault and disable.
    bus_if.en       = 1'b1;
    bus_if.d_target = DW'(50);
    for (int i = 0; i < 1500 && bus_if.d_out != 2; i++) cycle();
    chk("s6_d2", bus_if.d_out, 2);
    repeat (37) cycle();
    bus_if.en = 1'b0;
    cycle();
    chk("s6_idle", {bus_if.state, bus_if.d_out, bus_if.pwm_en}, {2'd0, DW'(0), 1'b0});
    bus_if.en = 1'b1;
    repeat (150) cycle();
    chk("s6_ramp", bus_if.state, 1);
    bus_if.fault = 1'b1;
    bus_if.en    = 1'b0;
    cycle();
    chk("s6_fault_wins", bus_if.state, 3);
    bus_if.fault     = 1'b0;
    bus_if.fault_clr = 1'b1;
    cycle();
    chk("s6_clr", bus_if.state, 0);
    bus_if.fault_clr = 1'b0;

    // Randomized segments checked cycle by cycle against the model.
    for (int s = 0; s < 30; s++) begin
      bus_if.en        = ($urandom_range(0, 9) != 0);
      r                = $urandom_range(0, 3);
      bus_if.d_target  = (r == 0) ? DW'($urandom_range(0, 1023)) : DW'($urandom_range(0, 12));
      bus_if.fault     = ($urandom_range(0, 7) == 0);
      bus_if.fault_clr = 1'($urandom_range(0, 1));
      len              = $urandom_range(1, 700);
      repeat (len) cycle();
      if (bus_if.fault) begin
        bus_if.fault = 1'b0;
        repeat ($urandom_range(1, 5)) cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
